decoder_nan_scan: RTL and testbench
===================================

Name: decoder_nan_scan

Overview:
- Parametrised N-to-2^N one-hot decoder with registered outputs and an auto-scan mode.
- Direct mode decodes input x with 1-cycle latency.
- Scan mode steps the active output 0,1,...,2^N-1,0,... with a programmable dwell per output.
- Drives digit/row enables for multiplexed displays and keypads; successor to the 3-to-8 dataflow decoder.

Parameters:
- N, 3: select width; output width is 2^N.
- DWELL_W, 8: width of the dwell (cycles-per-step) field.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- En  input  1  output enable; 0 forces y to all-zero and freezes scan.
- mode  input  1  0 = direct decode of x, 1 = auto-scan.
- x  input  N  select in direct mode; ignored in scan mode.
- load  input  1  1-cycle strobe: capture dwell and clear the dwell counter.
- dwell  input  DWELL_W  steps occur every dwell+1 enabled cycles.
- y  output  2^N  registered one-hot output (or all-zero).
- sel  output  N  registered current select index.
- wrap  output  1  1-cycle pulse when the scan steps from 2^N-1 to 0.

Behaviour:
- Reset values:
  - y=0, sel=0, wrap=0.
  - Internal dwell_q=0, cnt_q=0.
  - rst has priority over every other input, including mid-scan and coincident with load.
- Invariant: at every rising edge, y <= En ? onehot(sel_next) : 0, where sel_next is the value sel takes at that same edge. y therefore always matches sel whenever En was 1 on the previous cycle.
- load:
  - At the edge: dwell_q <= dwell and cnt_q <= 0, regardless of mode or En.
  - In scan mode, a load cycle does not step sel.
- Direct mode (mode=0):
  - sel <= x and cnt_q <= 0; wrap=0.
  - Latency x to y is 1 cycle.
  - En=0 still updates sel from x; only y is zeroed.
- Scan mode (mode=1, En=1, load=0):
  - If cnt_q==dwell_q: cnt_q <= 0 and sel <= sel+1 (mod 2^N). wrap <= 1 when sel was 2^N-1, else 0.
  - Otherwise: cnt_q <= cnt_q+1, sel holds, wrap <= 0.
  - dwell_q=0 steps every cycle. dwell_q=D holds each output for D+1 cycles.
- Scan mode, En=0:
  - sel and cnt_q hold; y=0; wrap=0.
  - Resuming with En=1 continues from the held sel and cnt_q.
- Mode switch direct->scan: scan starts from the current sel (the last x) with cnt_q=0. The first step occurs dwell_q+1 cycles after the switch.
- Mode switch scan->direct: at that edge sel <= x, and y follows on the same edge.
- Width rules:
  - sel increments modulo 2^N.
  - cnt_q is DWELL_W bits and never exceeds dwell_q.
  - When dwell_q is lowered below cnt_q by load, cnt_q is cleared, so there is no overrun.
- wrap is asserted only in scan mode and only for the single cycle in which sel becomes 0 by increment. It is never asserted by reset, load or direct mode.

Decomposition:
- No shared package required.
- Local constant OUT_W = 1<<N inside the module.
- One natural combinational sub-module, decoder_nan_onehot (N parameter; inputs x and En, output y), generalising the one-hot decode. It is instantiated on sel_next and its output feeds the y register.
- Counter, dwell register and mode logic stay in the top module.

Test Plan (N=3, DWELL_W=8):
1. Reset: hold rst=1 for 2 cycles with En=1, mode=1 -> y=8'h00, sel=0, wrap=0. Release -> first scan step follows the dwell_q=0 rule.
2. Direct decode: mode=0, En=1, x=5 at edge k -> y=8'h20 and sel=5 from edge k. Then En=0 -> y=8'h00 on the next edge while sel tracks x.
3. Scan, dwell=0: load with dwell=0, mode=1, En=1 -> y steps 8'h01,02,04,...,80,01 one per cycle. wrap=1 exactly in the cycle y returns to 8'h01, every 8 cycles.
4. Scan, dwell=2: load with dwell=2 -> each y value held for exactly 3 cycles. wrap pulse period is 24 cycles.
5. Freeze and resume: drop En for 5 cycles mid-dwell at sel=3 -> y=0 and wrap=0 during the freeze. After resume, y=8'h08 for the remaining dwell cycles, then 8'h10.
6. Corner cases:
   - Mode switch: x=6 direct, then mode=1 with dwell_q=1 -> y=8'h40 for 2 cycles, 8'h80 for 2 cycles, then 8'h01 with wrap=1.
   - rst asserted on the same edge as load -> dwell_q=0 and all outputs zero.

Source files
------------

// File: rtl/decoder_nan_scan_pkg.sv
// Shared types for the scanning one-hot decoder.
package decoder_nan_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/decoder_nan_onehot.sv
// Combinational N-to-2^N one-hot decoder; all-zero when En is low.
module decoder_nan_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0]        x,
  input  logic                En,
  output logic [(1<<N)-1:0]   y
);

  always_comb begin
    y = '0;
    if (En) y[x] = 1'b1;
  end

endmodule

// File: rtl/decoder_nan_scan.sv
// One-hot decoder with registered outputs: direct decode of x or auto-scan
// through all outputs with a programmable dwell per output.
module decoder_nan_scan
  import decoder_nan_scan_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                En,
  input  logic                mode,
  input  logic [N-1:0]        x,
  input  logic                load,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        sel,
  output logic                wrap
);

  localparam int OUT_W = 1 << N;

  scan_mode_e          mode_e;
  logic [DWELL_W-1:0]  dwell_q, dwell_next;
  logic [DWELL_W-1:0]  cnt_q, cnt_next;
  logic [N-1:0]        sel_next;
  logic                wrap_next;
  logic [OUT_W-1:0]    y_next;

  assign mode_e = scan_mode_e'(mode);

  // Next-state selection: load, then mode, then enable/dwell stepping.
  always_comb begin
    dwell_next = dwell_q;
    cnt_next   = cnt_q;
    sel_next   = sel;
    wrap_next  = 1'b0;
    if (load) begin
      dwell_next = dwell;
      cnt_next   = '0;
      if (mode_e == MODE_DIRECT) sel_next = x;
    end else if (mode_e == MODE_DIRECT) begin
      sel_next = x;
      cnt_next = '0;
    end else if (En) begin
      if (cnt_q == dwell_q) begin
        cnt_next  = '0;
        sel_next  = sel + 1'b1;
        wrap_next = (sel == {N{1'b1}});
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end
  end

  // y is decoded from the select value being registered on this same edge.
  decoder_nan_onehot #(.N(N)) u_onehot (
    .x  (sel_next),
    .En (En),
    .y  (y_next)
  );

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      sel     <= '0;
      wrap    <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      y       <= y_next;
      sel     <= sel_next;
      wrap    <= wrap_next;
      dwell_q <= dwell_next;
      cnt_q   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_decoder_nan_scan.sv
// Directed bench for decoder_nan_scan (N=3, DWELL_W=8): vector table plus scan loops.
module tb_decoder_nan_scan;

  logic       clk = 1'b0;
  logic       rst, En, mode, load;
  logic [2:0] x;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [2:0] sel;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, en, mode, load;
    logic [2:0] x;
    logic [7:0] dwell;
    logic [7:0] ey;
    logic [2:0] esel;
    logic       ew;
  } vec_t;

  vec_t tv[$];

  decoder_nan_scan #(.N(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .En    (En),
    .mode  (mode),
    .x     (x),
    .load  (load),
    .dwell (dwell),
    .y     (y),
    .sel   (sel),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic m, input logic ld,
                     input logic [2:0] xi, input logic [7:0] dw,
                     input logic [7:0] ey, input logic [2:0] es, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = ld; v.x = xi; v.dwell = dw;
    v.ey = ey; v.esel = es; v.ew = ew;
    tv.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic m, input logic ld,
                       input logic [2:0] xi, input logic [7:0] dw);
    @(negedge clk);
    rst = r; En = e; mode = m; load = ld; x = xi; dwell = dw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ey, input logic [2:0] es, input logic ew);
    checks++;
    if (y !== ey || sel !== es || wrap !== ew) begin
      errors++;
      $display("FAIL %s: got y=%h sel=%0d wrap=%b, want y=%h sel=%0d wrap=%b",
               nm, y, sel, wrap, ey, es, ew);
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(tv[i].rst, tv[i].en, tv[i].mode, tv[i].load, tv[i].x, tv[i].dwell);
      check($sformatf("vec%0d", i), tv[i].ey, tv[i].esel, tv[i].ew);
    end
  endtask

  initial begin
    int a_end, b_end;
    int wraps, first_wrap, second_wrap;
    logic [2:0] es;
    logic       ew;

    rst = 1'b1; En = 1'b0; mode = 1'b0; load = 1'b0; x = '0; dwell = '0;

    // Part A: reset, release into dwell 0 scan, direct decode with En gating
    add(1,1,1,0,0,0, 8'h00,0,0);
    add(1,1,1,0,0,0, 8'h00,0,0);
    add(0,1,1,0,0,0, 8'h02,1,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,0,0,5,0, 8'h20,5,0);
    add(0,0,0,0,5,0, 8'h00,5,0);
    add(0,0,0,0,2,0, 8'h00,2,0);
    add(0,1,0,0,3,0, 8'h08,3,0);
    a_end = tv.size();
    // Part B: freeze mid-dwell at sel=3 with dwell 2
    add(0,1,0,1,3,2, 8'h08,3,0);
    add(0,1,1,0,3,0, 8'h08,3,0);
    for (int k = 0; k < 5; k++) add(0,0,1,0,3,0, 8'h00,3,0);
    add(0,1,1,0,0,0, 8'h08,3,0);
    add(0,1,1,0,0,0, 8'h10,4,0);
    b_end = tv.size();
    // Part C: direct->scan switch with dwell 1, rst with load, dwell lowered mid-count
    add(0,1,0,1,6,1, 8'h40,6,0);
    add(0,1,1,0,0,0, 8'h40,6,0);
    add(0,1,1,0,0,0, 8'h80,7,0);
    add(0,1,1,0,0,0, 8'h80,7,0);
    add(0,1,1,0,0,0, 8'h01,0,1);
    add(0,1,1,0,0,0, 8'h01,0,0);
    add(0,1,1,0,0,0, 8'h02,1,0);
    add(1,1,1,1,0,5, 8'h00,0,0);
    add(0,1,1,0,0,0, 8'h02,1,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,1,1,0,4, 8'h04,2,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,1,1,0,1, 8'h04,2,0);
    add(0,1,1,0,0,0, 8'h04,2,0);
    add(0,1,1,0,0,0, 8'h08,3,0);

    run_table(0, a_end);

    // Scan with dwell 0 from sel=3: one step per cycle, wrap on each return to 0
    drive(0,1,1,1,0,0);
    check("load_d0", 8'h08, 3'd3, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(0,1,1,0,0,0);
      es = 3'((3 + i) % 8);
      ew = (es == 3'd0);
      check($sformatf("scan_d0_%0d", i), 8'h01 << es, es, ew);
    end

    // Scan with dwell 2 from sel=3: each output held 3 cycles, wrap every 24
    drive(0,1,1,1,0,2);
    check("load_d2", 8'h08, 3'd3, 1'b0);
    wraps = 0; first_wrap = -1; second_wrap = -1;
    for (int i = 1; i <= 48; i++) begin
      drive(0,1,1,0,0,0);
      es = 3'((3 + i / 3) % 8);
      ew = ((i % 3) == 0) && (es == 3'd0);
      check($sformatf("scan_d2_%0d", i), 8'h01 << es, es, ew);
      if (wrap === 1'b1) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i;
        else if (second_wrap < 0) second_wrap = i;
      end
    end
    checks++;
    if (wraps != 2 || (second_wrap - first_wrap) != 24) begin
      errors++;
      $display("FAIL wrap_period: got %0d pulses spaced %0d, want 2 pulses spaced 24",
               wraps, second_wrap - first_wrap);
    end

    run_table(a_end, b_end);
    run_table(b_end, tv.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
